// File: rtl/mac_tx_arbiter_if.sv
// Avalon-ST bundle between two packet sources, the arbiter and the MAC
// transmit FIFO port. The arbiter takes the slave side.
interface mac_tx_arbiter_if #(
    parameter int DW = 32
);
    logic [DW-1:0] i_data0;
    logic          i_vld0;
    logic          i_sop0;
    logic          i_eop0;
    logic          o_rdy0;
    logic [DW-1:0] i_data1;
    logic          i_vld1;
    logic          i_sop1;
    logic          i_eop1;
    logic          o_rdy1;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_vld;
    logic          o_tx_sop;
    logic          o_tx_eop;
    logic          i_tx_rdy;
    logic [1:0]    o_grant;
    logic [7:0]    o_err_cnt;

    modport master (
        output i_data0, i_vld0, i_sop0, i_eop0,
        output i_data1, i_vld1, i_sop1, i_eop1,
        output i_tx_rdy,
        input  o_rdy0, o_rdy1,
        input  o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop,
        input  o_grant, o_err_cnt
    );

    modport slave (
        input  i_data0, i_vld0, i_sop0, i_eop0,
        input  i_data1, i_vld1, i_sop1, i_eop1,
        input  i_tx_rdy,
        output o_rdy0, o_rdy1,
        output o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop,
        output o_grant, o_err_cnt
    );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Frame-level round-robin arbiter feeding the MAC transmit FIFO port.
// Optional frame length limit: define TX_ARB_MAXLEN_EN.
module mac_tx_arbiter #(
    parameter int DW        = 32,
    parameter int MAX_WORDS = 384
) (
    input  logic             clk,
    input  logic             rst_n,
    mac_tx_arbiter_if.slave  bus
);

    if (MAX_WORDS < 1 || MAX_WORDS > 65535) begin : g_bad_max_words
        $error("MAX_WORDS must be within 1..65535");
    end

`ifdef TX_ARB_MAXLEN_EN
    typedef enum logic [2:0] {IDLE, GNT0, GNT1, DROP0, DROP1} state_t;
    localparam logic [15:0] MAX_LAST = 16'(MAX_WORDS - 1);
    logic [15:0] cnt_q;
    logic        at_max;
`else
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
`endif

    state_t        state_q;
    logic          last_q;
    logic          first_q;
    logic [1:0]    grant_q;
    logic [7:0]    err_q;
    logic [7:0]    err_d;
    logic [DW-1:0] data_q;
    logic          vld_q;
    logic          sop_q;
    logic          eop_q;

    logic          elig0;
    logic          elig1;
    logic          rdy0;
    logic          rdy1;
    logic          sel1;
    logic          gnt_acc;
    logic          drop_acc;
    logic [DW-1:0] w_data;
    logic          w_sop;
    logic          w_eop;
    logic          w_eop_fwd;
    logic [1:0]    err_inc;
    logic [8:0]    err_sum;

    assign elig0 = bus.i_vld0 && bus.i_sop0;
    assign elig1 = bus.i_vld1 && bus.i_sop1;

    // Ready generation: orphan drop in IDLE, output-register room when
    // granted, unconditional sink while dropping an overlong tail.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        unique case (state_q)
            IDLE: begin
                rdy0 = bus.i_vld0 && !bus.i_sop0;
                rdy1 = bus.i_vld1 && !bus.i_sop1;
            end
            GNT0: rdy0 = !vld_q || bus.i_tx_rdy;
            GNT1: rdy1 = !vld_q || bus.i_tx_rdy;
`ifdef TX_ARB_MAXLEN_EN
            DROP0: rdy0 = 1'b1;
            DROP1: rdy1 = 1'b1;
`endif
            default: ;
        endcase
    end

    // Granted-port word mux, acceptance strobes and error increment.
    always_comb begin
`ifdef TX_ARB_MAXLEN_EN
        sel1     = (state_q == GNT1) || (state_q == DROP1);
        drop_acc = ((state_q == DROP0) && bus.i_vld0)
                || ((state_q == DROP1) && bus.i_vld1);
`else
        sel1     = (state_q == GNT1);
        drop_acc = 1'b0;
`endif
        gnt_acc = ((state_q == GNT0) && bus.i_vld0 && rdy0)
               || ((state_q == GNT1) && bus.i_vld1 && rdy1);
        w_data  = sel1 ? bus.i_data1 : bus.i_data0;
        w_sop   = sel1 ? bus.i_sop1 : bus.i_sop0;
        w_eop   = sel1 ? bus.i_eop1 : bus.i_eop0;
`ifdef TX_ARB_MAXLEN_EN
        at_max    = (cnt_q == MAX_LAST);
        w_eop_fwd = w_eop || at_max;
`else
        w_eop_fwd = w_eop;
`endif
        err_inc = 2'd0;
        if (state_q == IDLE) begin
            err_inc = 2'(bus.i_vld0 && !bus.i_sop0)
                    + 2'(bus.i_vld1 && !bus.i_sop1);
        end else if (gnt_acc) begin
            err_inc = 2'(w_sop && !first_q);
`ifdef TX_ARB_MAXLEN_EN
            err_inc = err_inc + 2'(at_max && !w_eop);
`endif
        end
        err_sum = {1'b0, err_q} + {7'd0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // Arbitration FSM, grant bookkeeping and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            first_q <= 1'b1;
            grant_q <= 2'b00;
            err_q   <= 8'd0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
`ifdef TX_ARB_MAXLEN_EN
            cnt_q   <= 16'd0;
`endif
        end else begin
            err_q <= err_d;
            if (gnt_acc) begin
                data_q <= w_data;
                sop_q  <= w_sop;
                eop_q  <= w_eop_fwd;
                vld_q  <= 1'b1;
            end else if (bus.i_tx_rdy) begin
                vld_q  <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    first_q <= 1'b1;
`ifdef TX_ARB_MAXLEN_EN
                    cnt_q   <= 16'd0;
`endif
                    if (elig0 && (!elig1 || last_q)) begin
                        state_q <= GNT0;
                        grant_q <= 2'b01;
                    end else if (elig1) begin
                        state_q <= GNT1;
                        grant_q <= 2'b10;
                    end
                end
                GNT0, GNT1: begin
                    if (gnt_acc) begin
                        first_q <= 1'b0;
`ifdef TX_ARB_MAXLEN_EN
                        cnt_q   <= cnt_q + 16'd1;
`endif
                        if (w_eop) begin
                            state_q <= IDLE;
                            grant_q <= 2'b00;
                            last_q  <= sel1;
`ifdef TX_ARB_MAXLEN_EN
                        end else if (at_max) begin
                            state_q <= sel1 ? DROP1 : DROP0;
`endif
                        end
                    end
                end
                default: begin
                    if (drop_acc && w_eop) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        last_q  <= sel1;
                    end
                end
            endcase
        end
    end

    assign bus.o_rdy0    = rdy0;
    assign bus.o_rdy1    = rdy1;
    assign bus.o_tx_data = data_q;
    assign bus.o_tx_vld  = vld_q;
    assign bus.o_tx_sop  = sop_q;
    assign bus.o_tx_eop  = eop_q;
    assign bus.o_grant   = grant_q;
    assign bus.o_err_cnt = err_q;

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Frame-level arbiter that shares the single MAC transmit FIFO port (32-bit Avalon-ST: data/vld/sop/eop/rdy) between two packet sources: port 0 (ADC data stream from the channel datapath) and port 1 (command replies / status frames). It grants whole frames only, round-robin, so frames from the two sources are never interleaved. It forwards them through one registered output stage into the MAC `ff_tx_*` inputs, all in the `sys_clk` domain.

## Interface
Parameters:
- `DW`, 32, data word width (matches MAC `ff_tx_data`)
- `MAX_WORDS`, 384, frame length limit in words; used only with `TX_ARB_MAXLEN_EN`

Ports:
- `clk`  in  1  system clock (`sys_clk`)
- `rst_n`  in  1  asynchronous, active-low reset
- `i_data0` / `i_data1`  in  DW  requester word
- `i_vld0` / `i_vld1`  in  1  requester word valid
- `i_sop0` / `i_sop1`  in  1  first word of frame
- `i_eop0` / `i_eop1`  in  1  last word of frame
- `o_rdy0` / `o_rdy1`  out  1  word accepted when `i_vldN && o_rdyN`
- `o_tx_data`  out  DW  to MAC `ff_tx_data`
- `o_tx_vld`  out  1  to MAC `ff_tx_wren`
- `o_tx_sop`  out  1  to MAC `ff_tx_sop`
- `o_tx_eop`  out  1  to MAC `ff_tx_eop`
- `i_tx_rdy`  in  1  from MAC `ff_tx_rdy`; output word consumed when `o_tx_vld && i_tx_rdy`
- `o_grant`  out  2  one-hot current grant (00 = none)
- `o_err_cnt`  out  8  saturating protocol-error counter

## Operation
- FSM states: IDLE, GNT0, GNT1, and, with the macro only, DROP0 and DROP1.
- IDLE:
  - A requester is eligible when `i_vldN && i_sopN`.
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one not served last. The `last` pointer resets to 1, so port 0 wins the first tie.
  - A requester presenting `i_vldN && !i_sopN` in IDLE is orphan data. It gets `o_rdyN=1`, the word is discarded, and `o_err_cnt` increments.
  - Eligible sop words are not accepted in IDLE (`o_rdyN=0`).
- GNTn:
  - `o_rdyn = !out_vld || i_tx_rdy`; the other port's `o_rdy` is 0.
  - Each accepted word loads the output register.
  - Acceptance of the word with `i_eopn=1` sets `last=n` and returns to IDLE on the next cycle.
  - A word with `i_sopn=1` accepted mid-frame (not the first word) is forwarded unchanged, and `o_err_cnt` increments.
- Output register:
  - It holds one word plus its sop/eop flags.
  - It holds its contents while `o_tx_vld && !i_tx_rdy`.
  - `o_tx_vld` clears after the consuming cycle unless it is reloaded in the same cycle.
- `o_err_cnt` saturates at 255 and is cleared only by reset.
- `o_grant` reflects the FSM state: 01 in GNT0/DROP0, 10 in GNT1/DROP1, 00 in IDLE.

## Timing
- Reset values: `o_tx_vld=0`, `o_tx_sop=0`, `o_tx_eop=0`, `o_tx_data=0`, `o_rdy0=0`, `o_rdy1=0`, `o_grant=00`, `o_err_cnt=0`. FSM=IDLE, `last=1`, word counter=0.
- Arbitration takes 1 cycle. An eligible sop seen in IDLE at cycle t gives grant at t+1, and the sop word can be accepted at t+1.
- Latency: a word accepted at cycle t appears on `o_tx_*` at t+1.
- Throughput: 1 word/cycle with `i_tx_rdy` held high.
- Gap between frames: at least 1 idle cycle on the output (the IDLE cycle).
- Back-to-back frames alternate under contention. A requester continuously offering frames receives at most every other grant while the other port is also offering.
- `i_tx_rdy` low: `o_rdyn` follows combinationally, and no word is lost or duplicated.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). The partial frame is abandoned, and the MAC sees `o_tx_vld` drop with no eop.
- Simultaneous events:
  - An orphan word on one port and an eligible sop on the other in IDLE: the orphan is dropped and the sop is granted in the same cycle.
  - Both ports orphan in the same cycle: `o_err_cnt` increments by 2, saturating.

## Configuration
- `TX_ARB_MAXLEN_EN` defined:
  - A 16-bit counter counts words accepted in the current grant.
  - When the `MAX_WORDS`-th word is accepted without `i_eop`, it is forwarded with `o_tx_eop` forced to 1, and `o_err_cnt` increments.
  - The FSM then enters DROPn. In DROPn, `o_rdyn=1` and words are discarded until `i_eopn` is accepted; then `last=n` and the FSM goes to IDLE.
  - A frame of exactly `MAX_WORDS` words ending in eop is normal and is not counted as an error.
- Macro undefined:
  - There is no counter and no DROP states; frame length is unlimited.
  - `MAX_WORDS` is ignored.

## Test plan
- Port 0 sends a 4-word frame (A0..A3), port 1 idle, `i_tx_rdy=1` → output A0..A3 on consecutive cycles starting 2 cycles after sop is presented. `o_tx_sop` is set on A0 and `o_tx_eop` on A3. `o_grant`=01 during the frame, then 00.
- Both ports present sop in the same cycle after reset, 3-word frames each, repeated twice → output order P0, P1, P0, P1, with no interleaving and one idle cycle between frames.
- Port 1 sends 8 words; `i_tx_rdy` is low for 3 cycles after the 2nd output word → `o_rdy1` is low for those cycles and `o_tx_data` holds word 2. All 8 words are delivered exactly once, in order.
- In IDLE, port 0 presents 2 words with `i_vld0=1` and `i_sop0=0` → both are accepted and discarded, nothing appears on output, and `o_err_cnt`=2.
- `TX_ARB_MAXLEN_EN`, `MAX_WORDS=4`, port 0 sends a 6-word frame then a 2-word frame → output is 4 words with eop on the 4th, then the 2-word frame. Words 5–6 are discarded, and `o_err_cnt`=1.
- `rst_n` pulsed low during word 3 of a 6-word frame → `o_tx_vld`, `o_grant` and `o_err_cnt` are 0 immediately. A new frame after release is delivered normally, with port 0 winning the tie.
